// File: rtl/fib_pkg.sv
// Shared encodings for the Fibonacci controller: ALU opcodes, operand-mux
// selects and the controller state enumeration.
package fib_pkg;

  localparam logic [2:0] OP_ZERO  = 3'b000;
  localparam logic [2:0] OP_ONE   = 3'b001;
  localparam logic [2:0] OP_INC   = 3'b010;
  localparam logic [2:0] OP_DEC   = 3'b011;
  localparam logic [2:0] OP_PASS1 = 3'b100;
  localparam logic [2:0] OP_ADD   = 3'b110;
  localparam logic [2:0] OP_PASS2 = 3'b111;

  localparam logic [1:0] IN1_A = 2'd0;
  localparam logic [1:0] IN1_B = 2'd1;
  localparam logic [1:0] IN1_C = 2'd2;
  localparam logic [1:0] IN1_N = 2'd3;

  localparam logic [1:0] IN2_A = 2'd0;
  localparam logic [1:0] IN2_B = 2'd1;
  localparam logic [1:0] IN2_T = 2'd2;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_INIT_A = 4'd1,
    S_INIT_B = 4'd2,
    S_LOAD_C = 4'd3,
    S_DEC_C  = 4'd4,
    S_ADD_T  = 4'd5,
    S_MOV_A  = 4'd6,
    S_MOV_B  = 4'd7,
    S_CLR_B  = 4'd8,
    S_DONE   = 4'd9
  } state_e;

endpackage

// File: rtl/fib_controller_if.sv
// Request handshake plus the control bus between the Fibonacci controller
// (master) and its requester/datapath (slave).
interface fib_controller_if #(
  parameter int SIZE = 4
);

  logic            start;
  logic [SIZE-1:0] n;
  logic            zero_flag;
  logic [SIZE-1:0] n_q;
  logic [2:0]      alu_opcode;
  logic [1:0]      in1_sel;
  logic [1:0]      in2_sel;
  logic            we_a;
  logic            we_b;
  logic            we_t;
  logic            we_c;
  logic            busy;
  logic            done;

  modport master (
    input  start, n, zero_flag,
    output n_q, alu_opcode, in1_sel, in2_sel,
    output we_a, we_b, we_t, we_c, busy, done
  );

  modport slave (
    output start, n, zero_flag,
    input  n_q, alu_opcode, in1_sel, in2_sel,
    input  we_a, we_b, we_t, we_c, busy, done
  );

endinterface

// File: rtl/fib_controller.sv
// Moore FSM that sequences a shared ALU and the A/B/T/C registers to leave
// F(n) in B. Only the latched n is held here; all other values live in the datapath.
module fib_controller
  import fib_pkg::*;
#(
  parameter int SIZE = 4
) (
  input  logic             clk,
  input  logic             rst,
  fib_controller_if.master bus
);

  state_e          state_q, state_d;
  logic [SIZE-1:0] n_latch_q, n_latch_d;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      n_latch_q <= '0;
    end else begin
      state_q   <= state_d;
      n_latch_q <= n_latch_d;
    end
  end

  assign bus.n_q = n_latch_q;

  // NOTE: every output gets a default before the case so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_d        = state_q;
    n_latch_d      = n_latch_q;
    bus.alu_opcode = OP_ZERO;
    bus.in1_sel    = IN1_A;
    bus.in2_sel    = IN2_A;
    bus.we_a       = 1'b0;
    bus.we_b       = 1'b0;
    bus.we_t       = 1'b0;
    bus.we_c       = 1'b0;
    bus.busy       = 1'b1;
    bus.done       = 1'b0;

    case (state_q)
      S_IDLE: begin
        bus.busy = 1'b0;
        if (bus.start) begin
          n_latch_d = bus.n;
          state_d   = S_INIT_A;
        end
      end
      S_INIT_A: begin
        bus.we_a = 1'b1;
        state_d  = S_INIT_B;
      end
      S_INIT_B: begin
        bus.alu_opcode = OP_ONE;
        bus.we_b       = 1'b1;
        state_d        = S_LOAD_C;
      end
      // n == 0 shows up as a zero result while C is loaded.
      S_LOAD_C: begin
        bus.alu_opcode = OP_PASS1;
        bus.in1_sel    = IN1_N;
        bus.we_c       = 1'b1;
        state_d        = bus.zero_flag ? S_CLR_B : S_DEC_C;
      end
      S_DEC_C: begin
        bus.alu_opcode = OP_DEC;
        bus.in1_sel    = IN1_C;
        bus.we_c       = 1'b1;
        state_d        = bus.zero_flag ? S_DONE : S_ADD_T;
      end
      S_ADD_T: begin
        bus.alu_opcode = OP_ADD;
        bus.in1_sel    = IN1_A;
        bus.in2_sel    = IN2_B;
        bus.we_t       = 1'b1;
        state_d        = S_MOV_A;
      end
      S_MOV_A: begin
        bus.alu_opcode = OP_PASS2;
        bus.in2_sel    = IN2_B;
        bus.we_a       = 1'b1;
        state_d        = S_MOV_B;
      end
      S_MOV_B: begin
        bus.alu_opcode = OP_PASS2;
        bus.in2_sel    = IN2_T;
        bus.we_b       = 1'b1;
        state_d        = S_DEC_C;
      end
      S_CLR_B: begin
        bus.we_b = 1'b1;
        state_d  = S_DONE;
      end
      S_DONE: begin
        bus.done = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule
